hazard_detection_unit: RTL

- Stall/flush controller for the 5-stage MIPS pipeline; the counterpart of the forwarding logic.
- Forwarding resolves hazards by bypassing. This block covers the hazards bypassing cannot fix: load-use, taken branch resolved in MEM, and variable-latency data-memory waits.
- It drives PC write enable, IF/ID write enable, per-stage flushes, and a global pipeline hold.
- Contains an FSM, a wait/timeout counter and optional performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/hazard_detection_unit_sat_counter.sv | 20 ++
 rtl/hazard_detection_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM encoding and register-index type.
// Used by the hazard detection unit and the forwarding unit.
package pipeline_ctrl_pkg;

    typedef logic [4:0] regIdx_t;

    localparam regIdx_t ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } hazState_e;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Instantiated for the hazard unit performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller: load-use, taken branch in MEM, data-memory waits.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_detection_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  regIdx_t          ID_RegisterRs,
    input  regIdx_t          ID_RegisterRt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  regIdx_t          EX_RegisterRt,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             dmem_ready,
    input  logic             MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hazState_e  state;
    hazState_e  nextState;
    logic [7:0] waitCnt;
    logic [7:0] nextWaitCnt;
    logic       timeoutHit;
    logic       loadUse;
    logic       memBusy;
    logic       evalRun;
    logic       takeBranch;
    logic       doStall;

    assign loadUse = EX_MemRead && (EX_RegisterRt != ZERO_REG) &&
                     ((EX_RegisterRt == ID_RegisterRs) ||
                      (ID_UsesRt && (EX_RegisterRt == ID_RegisterRt)));

    assign memBusy = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;

    // Branch/load-use are only evaluated when nothing holds the pipeline
    assign evalRun = ((state == RUN) && !memBusy) ||
                     ((state == MEM_WAIT) && dmem_ready);

    assign takeBranch = evalRun && MEM_BranchTaken;
    assign doStall    = evalRun && !MEM_BranchTaken && loadUse;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            waitCnt     <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (timeoutHit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        timeoutHit  = 1'b0;
        unique case (state)
            RUN: begin
                if (memBusy) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    nextState   = RUN;
                    nextWaitCnt = 8'd0;
                end else begin
                    nextWaitCnt = waitCnt + 8'd1;
                    if (waitCnt == 8'(MEM_TIMEOUT)) begin
                        nextState  = ERROR;
                        timeoutHit = 1'b1;
                    end
                end
            end
            ERROR: begin
                nextState = ERROR;
            end
            default: begin
                nextState   = RUN;
                nextWaitCnt = 8'd0;
            end
        endcase
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        pipe_hold   = 1'b0;
        if (rst_i) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
        end else begin
            unique case (1'b1)
                !evalRun: begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    pipe_hold  = 1'b1;
                end
                takeBranch: begin
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                end
                doStall: begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) stallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (!PCWrite && !rst_i),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) flushCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (EXMEM_Flush),
        .count (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
